// File: rtl/flit_stream_sink.sv
// flit_stream_sink: terminates one NoC output channel.
// Accepts flits on a valid/ready handshake, reports throughput once per
// 2^WINDOW_LOG2-cycle window, keeps a wrapping 32-bit flit total, counts
// out-of-order sequence fields (saturating) and holds the last payload.
// Optional feature macro: SINK_RAND_STALL_EN -- when defined, an 8-bit
// Galois LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) throttles in_ready against
// STALL_THRESH. When undefined, no LFSR exists and in_ready is held at 1
// from the first edge after reset.
module flit_stream_sink #(
  parameter int WIDTH        = 8,
  parameter int WINDOW_LOG2  = 10,
  parameter int CNT_W        = 26,
  parameter int SEQ_W        = 4,
  parameter int STALL_THRESH = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [CNT_W-1:0] throughput,
  output logic             throughput_valid,
  output logic [31:0]      total_flits,
  output logic [15:0]      seq_errors,
  output logic [WIDTH-1:0] last_flit
);

  // Parameter legality is checked at elaboration so a bad configuration
  // never reaches synthesis silently.
  if (CNT_W < WINDOW_LOG2 + 1) begin : g_bad_cnt_w
    $error("flit_stream_sink: CNT_W must be at least WINDOW_LOG2+1");
  end
  if (SEQ_W > WIDTH) begin : g_bad_seq_w
    $error("flit_stream_sink: SEQ_W must not exceed WIDTH");
  end
  if ((STALL_THRESH < 0) || (STALL_THRESH > 255)) begin : g_bad_thresh
    $error("flit_stream_sink: STALL_THRESH must be within 0..255");
  end

  localparam logic [WINDOW_LOG2-1:0] WIN_ONE = WINDOW_LOG2'(1);
  localparam logic [SEQ_W-1:0]       SEQ_ONE = SEQ_W'(1);
  localparam logic [15:0]            ERR_MAX = 16'hFFFF;

  // State registers and their next-state values.
  logic                   in_ready_q,   in_ready_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q,    win_cnt_d;
  logic [CNT_W-1:0]       running_q,    running_d;
  logic [CNT_W-1:0]       throughput_q, throughput_d;
  logic                   tp_valid_q,   tp_valid_d;
  logic [31:0]            total_q,      total_d;
  logic [15:0]            seq_err_q,    seq_err_d;
  logic [SEQ_W-1:0]       exp_seq_q,    exp_seq_d;
  logic [WIDTH-1:0]       last_q,       last_d;

  logic                   accept_s;
  logic [CNT_W-1:0]       accept_ext_s;
  logic [SEQ_W-1:0]       seq_s;

  // Handshake decode: a flit transfers on this edge when valid meets the
  // registered ready; the sequence field sits in the low payload bits.
  always_comb begin
    accept_s     = in_valid && in_ready_q;
    accept_ext_s = CNT_W'(accept_s);
    seq_s        = in_data[SEQ_W-1:0];
  end

  // Throughput window: the accept landing on the last window cycle is
  // folded into the reported value so no accept is lost or counted twice.
  always_comb begin
    win_cnt_d    = win_cnt_q + WIN_ONE;
    throughput_d = throughput_q;
    running_d    = running_q;
    tp_valid_d   = 1'b0;
    if (&win_cnt_q) begin
      throughput_d = running_q + accept_ext_s;
      tp_valid_d   = 1'b1;
      running_d    = {CNT_W{1'b0}};
    end else begin
      running_d    = running_q + accept_ext_s;
      tp_valid_d   = 1'b0;
    end
  end

  // Per-accept bookkeeping: total, last payload and the sequence check.
  // A mismatch resyncs the expected value to the received one so a single
  // gap is reported once, not on every following flit.
  always_comb begin
    total_d   = total_q;
    seq_err_d = seq_err_q;
    exp_seq_d = exp_seq_q;
    last_d    = last_q;
    if (accept_s) begin
      total_d   = total_q + 32'd1;
      last_d    = in_data;
      exp_seq_d = seq_s + SEQ_ONE;
      if ((seq_s != exp_seq_q) && (seq_err_q != ERR_MAX)) begin
        seq_err_d = seq_err_q + 16'd1;
      end else begin
        seq_err_d = seq_err_q;
      end
    end else begin
      total_d   = total_q;
    end
  end

`ifdef SINK_RAND_STALL_EN
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] THRESH_VAL = 8'(STALL_THRESH);

  logic [7:0] lfsr_q, lfsr_d;

  // Right-shifting Galois LFSR; ready is granted when the current state
  // lies above the threshold, giving a deterministic 255-cycle pattern.
  always_comb begin
    if (lfsr_q[0]) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ LFSR_TAPS;
    end else begin
      lfsr_d = {1'b0, lfsr_q[7:1]};
    end
    in_ready_d = (lfsr_q > THRESH_VAL);
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Without the stall generator the sink is always willing once out of reset.
  always_comb begin
    in_ready_d = 1'b1;
  end
`endif

  // Main state register; reset discards any partial window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q   <= 1'b0;
      win_cnt_q    <= {WINDOW_LOG2{1'b0}};
      running_q    <= {CNT_W{1'b0}};
      throughput_q <= {CNT_W{1'b0}};
      tp_valid_q   <= 1'b0;
      total_q      <= 32'd0;
      seq_err_q    <= 16'd0;
      exp_seq_q    <= {SEQ_W{1'b0}};
      last_q       <= {WIDTH{1'b0}};
    end else begin
      in_ready_q   <= in_ready_d;
      win_cnt_q    <= win_cnt_d;
      running_q    <= running_d;
      throughput_q <= throughput_d;
      tp_valid_q   <= tp_valid_d;
      total_q      <= total_d;
      seq_err_q    <= seq_err_d;
      exp_seq_q    <= exp_seq_d;
      last_q       <= last_d;
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    in_ready         = in_ready_q;
    throughput       = throughput_q;
    throughput_valid = tp_valid_q;
    total_flits      = total_q;
    seq_errors       = seq_err_q;
    last_flit        = last_q;
  end

endmodule

// File: tb/tb_flit_stream_sink.sv
// Scoreboard bench for flit_stream_sink (WINDOW_LOG2=4, SEQ_W=4).
// Stimulus pushes expected flit statistics and throughput pulses into
// queues; a negedge monitor pops and compares when the DUT presents them.
module tb_flit_stream_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [25:0] throughput;
  logic        throughput_valid;
  logic [31:0] total_flits;
  logic [15:0] seq_errors;
  logic [7:0]  last_flit;

  flit_stream_sink #(
    .WIDTH(8), .WINDOW_LOG2(4), .CNT_W(26), .SEQ_W(4), .STALL_THRESH(128)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .throughput(throughput),
    .throughput_valid(throughput_valid), .total_flits(total_flits),
    .seq_errors(seq_errors), .last_flit(last_flit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct { int c; int v; } tp_t;
  typedef struct { logic [31:0] tot; logic [15:0] err; logic [7:0] last; } st_t;
  tp_t exp_tp[$];
  st_t exp_st[$];

  logic [31:0] m_tot;
  logic [15:0] m_err;
  logic [3:0]  m_exp;
  logic [7:0]  m_last;
  bit          pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges since reset release; cyc==k at the negedge after edge k.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: compare per-flit statistics after each accept and every
  // throughput pulse against the queued expectations.
  always @(negedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (exp_st.size() == 0) begin
          check("unexpected_accept", 64'd1, 64'd0);
        end else begin
          check("total_flits", total_flits, exp_st[0].tot);
          check("seq_errors", seq_errors, exp_st[0].err);
          check("last_flit", last_flit, exp_st[0].last);
          exp_st.pop_front();
        end
      end
      if (throughput_valid) begin
        if (exp_tp.size() == 0) begin
          check("unexpected_tp_pulse", 64'(cyc), 64'd0);
        end else begin
          check("tp_cycle", 64'(cyc), 64'(exp_tp[0].c));
          check("tp_value", throughput, 64'(exp_tp[0].v));
          exp_tp.pop_front();
        end
      end
      pend <= in_valid && in_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_accept(input logic [7:0] d);
    if ((d[3:0] != m_exp) && (m_err != 16'hFFFF)) m_err = m_err + 16'd1;
    m_exp  = d[3:0] + 4'd1;
    m_tot  = m_tot + 32'd1;
    m_last = d;
    exp_st.push_back('{m_tot, m_err, m_last});
  endtask

  // Present one flit and hold it until the edge that accepts it.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 64) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      model_accept(d);
      tick(1);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    m_tot = 32'd0; m_err = 16'd0; m_exp = 4'd0; m_last = 8'd0;
    repeat (n) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 64'd0);
      check("rst_throughput", throughput, 64'd0);
      check("rst_tp_valid", throughput_valid, 64'd0);
      check("rst_total", total_flits, 64'd0);
      check("rst_seq_errors", seq_errors, 64'd0);
      check("rst_last_flit", last_flit, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("ready_before_edge1", in_ready, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SINK_RAND_STALL_EN
    logic [7:0] lfsr;
    bit         r_before;
    int         acc;
    int         win_acc;
    logic [7:0] d;
`endif
    do_reset(5);
`ifndef SINK_RAND_STALL_EN
    // Continuous traffic: windows of 15 (late ready), 16, then 9.
    tick(1);
    check("ready_after_edge1", in_ready, 64'd1);
    exp_tp.push_back('{16, 15});
    exp_tp.push_back('{32, 16});
    exp_tp.push_back('{48, 9});
    for (int i = 0; i < 40; i++) send(8'(i));
    in_valid = 1'b0;
    in_data  = 8'hEE;
    while (cyc < 50) tick(1);

    // Seven accepts, then reset mid-window; the partial count must vanish.
    do_reset(2);
    for (int i = 0; i < 7; i++) send(8'h20 | 8'(i));
    in_valid = 1'b0;
    tick(1);
    do_reset(3);

    // Gap 2->5 gives one error, then 8..15 and the 15->0 wrap give none.
    exp_tp.push_back('{16, 15});
    exp_tp.push_back('{32, 1});
    exp_tp.push_back('{48, 0});
    send(8'h30); send(8'h31); send(8'h32);
    send(8'h35); send(8'h36); send(8'h37);
    for (int i = 8; i < 14; i++) send(8'h40 | 8'(i));
    send(8'h5E); send(8'h5F); send(8'h50); send(8'h51);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    while (cyc < 50) tick(1);
    check("final_total", total_flits, 64'd16);
    check("final_seq_errors", seq_errors, 64'd1);
    check("final_last_flit", last_flit, 64'h51);
`else
    // Stall mode: ready follows the reference LFSR from 8'hA5; one full
    // period grants 127 accepts (states 129..255).
    lfsr = 8'hA5;
    acc = 0;
    win_acc = 0;
    d = 8'h00;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 1; k <= 256; k++) begin
      r_before = in_ready;
      tick(1);
      if (r_before) begin
        model_accept(d);
        acc++;
        win_acc++;
        d = d + 8'd1;
        in_data = d;
      end
      if ((k % 16) == 0) begin
        exp_tp.push_back('{k, win_acc});
        win_acc = 0;
      end
      check("ready_lfsr", in_ready, 64'(lfsr > 8'd128));
      lfsr = lfsr[0] ? ({1'b0, lfsr[7:1]} ^ 8'hB8) : {1'b0, lfsr[7:1]};
    end
    in_valid = 1'b0;
    tick(1);
    check("stall_accept_count", 64'(acc), 64'd127);
    check("stall_total", total_flits, 64'd127);
    check("stall_seq_errors", seq_errors, 64'd0);
`endif
    check("tp_queue_drained", 64'(exp_tp.size()), 64'd0);
    check("st_queue_drained", 64'(exp_st.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
